y86_hazard_unit: RTL and testbench



---
 rtl/y86_pkg.sv | 62 ++++++
 rtl/y86_hazard_detect.sv | 30 +++
 rtl/y86_hazard_unit.sv | 166 ++++++++++++++++
 tb/tb_y86_hazard_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared constants and types for the Y86-64 pipeline control logic.
// Also holds the control-bundle helpers used by y86_hazard_unit.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // One-hot status codes
    localparam logic [3:0] SAOK = 4'b1000;
    localparam logic [3:0] SHLT = 4'b0100;
    localparam logic [3:0] SADR = 4'b0010;
    localparam logic [3:0] SINS = 4'b0001;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } haz_state_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic e_stall;
        logic m_stall;
        logic w_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_bubble;
        logic setcc;
    } haz_ctrl_t;

    // Normal-flow controls from the three hazard terms (setcc left at 0)
    function automatic haz_ctrl_t run_ctrl(input logic load_use, input logic ret_pend,
                                           input logic mispred);
        haz_ctrl_t c;
        c          = '0;
        c.f_stall  = load_use | ret_pend;
        c.d_stall  = load_use;
        c.e_bubble = mispred | load_use;
        c.d_bubble = mispred | (ret_pend & ~load_use);
        return c;
    endfunction

    // Freeze F..M and push a bubble into W while data memory is busy
    function automatic haz_ctrl_t wait_ctrl();
        haz_ctrl_t c;
        c          = '0;
        c.f_stall  = 1'b1;
        c.d_stall  = 1'b1;
        c.e_stall  = 1'b1;
        c.m_stall  = 1'b1;
        c.w_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/y86_hazard_detect.sv
// Combinational hazard terms: load/use, pending ret, and branch mispredict.
module y86_hazard_detect
    import y86_pkg::*;
#(
    parameter int               REG_W  = 4,
    parameter logic [REG_W-1:0] NO_REG = '1
) (
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [REG_W-1:0] d_srcA,
    input  logic [REG_W-1:0] d_srcB,
    input  logic [REG_W-1:0] E_dstM,
    input  logic             e_Cnd,
    output logic             load_use,
    output logic             ret_pend,
    output logic             mispred
);

    // A load in E whose destination feeds a decode source; NO_REG never matches
    assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                      (E_dstM != NO_REG) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    assign ret_pend = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);

    // Branches are predicted taken, so a not-taken jXX is a mispredict
    assign mispred  = (E_icode == IJXX) && !e_Cnd;

endmodule

// File: rtl/y86_hazard_unit.sv
// Registered pipeline-control unit: stall/bubble/setcc generation with a
// data-memory wait handshake (timeout) and an exception drain/halt FSM.
// Optional hazard performance counters are built when HAZ_PERF_CNT_EN is defined.
module y86_hazard_unit
    import y86_pkg::*;
#(
    parameter int               REG_W       = 4,
    parameter logic [REG_W-1:0] NO_REG      = '1,
    parameter int               MEM_TIMEOUT = 16,
    parameter int               CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [REG_W-1:0] d_srcA,
    input  logic [REG_W-1:0] d_srcB,
    input  logic [REG_W-1:0] E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             setcc,
    output logic             halted,
    output logic             mem_timeout
`ifdef HAZ_PERF_CNT_EN
   ,output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_mispred,
    output logic [CNT_W-1:0] cnt_ret,
    output logic [CNT_W-1:0] cnt_memwait
`endif
);

    localparam int              WC_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    haz_state_t      state_q, state_d;
    haz_ctrl_t       ctrl;
    logic [WC_W-1:0] wcnt_q;
    logic            load_use, ret_pend, mispred, mem_wait, timeout;
    logic            m_aok, w_aok;

    y86_hazard_detect #(.REG_W(REG_W), .NO_REG(NO_REG)) u_detect (
        .D_icode  (D_icode),
        .E_icode  (E_icode),
        .M_icode  (M_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .load_use (load_use),
        .ret_pend (ret_pend),
        .mispred  (mispred)
    );

    assign mem_wait = m_mem_req && !m_mem_ready;
    assign m_aok    = (m_stat == SAOK);
    assign w_aok    = (W_stat == SAOK);
    // Ready on the last allowed cycle still wins over the timeout
    assign timeout  = (MEM_TIMEOUT != 0) && (state_q == ST_MWAIT) && !m_mem_ready &&
                      (wcnt_q == WC_LAST);

    // Next-state and control outputs from current state and inputs
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait)    ctrl = wait_ctrl();
                else if (!m_aok) ctrl.m_bubble = 1'b1;
                else             ctrl = run_ctrl(load_use, ret_pend, mispred);
                ctrl.setcc = !mem_wait && (E_icode != IHALT) && m_aok && w_aok;
                // A retiring exception beats a concurrent memory wait
                if (!w_aok)        state_d = ST_HALT;
                else if (mem_wait) state_d = ST_MWAIT;
                else if (!m_aok)   state_d = ST_DRAIN;
            end
            ST_MWAIT: begin
                if (!m_mem_ready) ctrl = wait_ctrl();
                else if (!m_aok)  ctrl.m_bubble = 1'b1;
                else              ctrl = run_ctrl(load_use, ret_pend, mispred);
                if (m_mem_ready)  state_d = ST_RUN;
                else if (timeout) state_d = ST_HALT;
            end
            ST_DRAIN: begin
                ctrl.f_stall  = 1'b1;
                ctrl.d_stall  = 1'b1;
                ctrl.m_bubble = 1'b1;
                ctrl.w_stall  = !w_aok;
                if (!w_aok) state_d = ST_HALT;
            end
            ST_HALT: begin
                ctrl.f_stall = 1'b1;
                ctrl.d_stall = 1'b1;
                ctrl.e_stall = 1'b1;
                ctrl.m_stall = 1'b1;
                ctrl.w_stall = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_RUN && state_d == ST_MWAIT)
                wcnt_q <= '0;
            else if (state_q == ST_MWAIT && !m_mem_ready)
                wcnt_q <= wcnt_q + WC_W'(1);
            if (timeout)
                mem_timeout <= 1'b1;
        end
    end

    assign F_stall  = ctrl.f_stall;
    assign D_stall  = ctrl.d_stall;
    assign E_stall  = ctrl.e_stall;
    assign M_stall  = ctrl.m_stall;
    assign W_stall  = ctrl.w_stall;
    assign D_bubble = ctrl.d_bubble;
    assign E_bubble = ctrl.e_bubble;
    assign M_bubble = ctrl.m_bubble;
    assign W_bubble = ctrl.w_bubble;
    assign setcc    = ctrl.setcc;
    assign halted   = (state_q == ST_HALT);

`ifdef HAZ_PERF_CNT_EN
    logic [3:0]            cnt_inc;
    logic [3:0][CNT_W-1:0] cnt_q;

    assign cnt_inc = {mem_wait, ret_pend, mispred, load_use};

    // Saturating event counters, live only in RUN/MWAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_RUN || state_q == ST_MWAIT) begin
            for (int i = 0; i < 4; i++)
                if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}}))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
    end

    assign cnt_loaduse = cnt_q[0];
    assign cnt_mispred = cnt_q[1];
    assign cnt_ret     = cnt_q[2];
    assign cnt_memwait = cnt_q[3];
`endif

endmodule

// File: tb/tb_y86_hazard_unit.sv
// Self-checking bench for y86_hazard_unit: directed scenarios then random
// stimulus against a cycle-level reference model. Counter checks are built
// when HAZ_PERF_CNT_EN is defined.
module tb_y86_hazard_unit;

    localparam int REG_W = 4;
    localparam int TO    = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       D_icode, E_icode, M_icode;
    logic [REG_W-1:0] d_srcA, d_srcB, E_dstM;
    logic             e_Cnd;
    logic [3:0]       m_stat, W_stat;
    logic             m_mem_req, m_mem_ready;
    logic             F_stall, D_stall, E_stall, M_stall, W_stall;
    logic             D_bubble, E_bubble, M_bubble, W_bubble;
    logic             setcc, halted, mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0]    cnt_loaduse, cnt_mispred, cnt_ret, cnt_memwait;
`endif

    always #5 clk = ~clk;

    y86_hazard_unit #(.REG_W(REG_W), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .W_bubble(W_bubble), .setcc(setcc), .halted(halted), .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
       ,.cnt_loaduse(cnt_loaduse), .cnt_mispred(cnt_mispred),
        .cnt_ret(cnt_ret), .cnt_memwait(cnt_memwait)
`endif
    );

    // {stalls F..W, bubbles D..W, setcc, halted, mem_timeout}
    logic [11:0] dut_vec;
    logic [8:0]  ctrl9;
    assign dut_vec = {F_stall, D_stall, E_stall, M_stall, W_stall,
                      D_bubble, E_bubble, M_bubble, W_bubble, setcc, halted, mem_timeout};
    assign ctrl9   = dut_vec[11:3];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: 0 running, 1 waiting on memory, 2 draining, 3 halted
    int mode;
    int waited;
    bit timed_out;
    int events[4];   // loaduse, mispred, ret, memwait

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit t_loaduse();
        return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction
    function automatic bit t_ret();
        return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    endfunction
    function automatic bit t_mispred();
        return E_icode == 4'h7 && !e_Cnd;
    endfunction
    function automatic bit t_memwait();
        return m_mem_req && !m_mem_ready;
    endfunction

    function automatic logic [11:0] expect_out();
        bit lu, rp, mp, mw, maok, waok;
        logic fs, ds, es, ms, ws, db, eb, mb, wb, sc;
        lu = t_loaduse(); rp = t_ret(); mp = t_mispred(); mw = t_memwait();
        maok = (m_stat == 4'b1000);
        waok = (W_stat == 4'b1000);
        {fs, ds, es, ms, ws, db, eb, mb, wb} = '0;
        if (mode == 3) begin
            {fs, ds, es, ms, ws} = 5'b11111;
        end else if (mode == 2) begin
            fs = 1; ds = 1; mb = 1; ws = !waok;
        end else if ((mode == 0 && mw) || (mode == 1 && !m_mem_ready)) begin
            {fs, ds, es, ms, wb} = 5'b11111;
        end else if (!maok) begin
            mb = 1;
        end else begin
            fs = lu | rp;
            ds = lu;
            eb = mp | lu;
            db = mp | (rp & !lu);
        end
        sc = (mode == 0) && !mw && E_icode != 4'h0 && maok && waok;
        return {fs, ds, es, ms, ws, db, eb, mb, wb, sc, (mode == 3), timed_out};
    endfunction

    task automatic model_clock();
        bit term[4];
        term[0] = t_loaduse(); term[1] = t_mispred(); term[2] = t_ret(); term[3] = t_memwait();
        if (mode == 0 || mode == 1)
            for (int i = 0; i < 4; i++)
                if (term[i] && events[i] < (1 << CW) - 1) events[i]++;
        case (mode)
            0: if (W_stat != 4'b1000) mode = 3;
               else if (t_memwait()) begin mode = 1; waited = 0; end
               else if (m_stat != 4'b1000) mode = 2;
            1: if (m_mem_ready) mode = 0;
               else if (waited == TO - 1) begin mode = 3; timed_out = 1; end
               else waited++;
            2: if (W_stat != 4'b1000) mode = 3;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        mode = 0; waited = 0; timed_out = 0;
        for (int i = 0; i < 4; i++) events[i] = 0;
    endtask

    task automatic chk_cnt();
`ifdef HAZ_PERF_CNT_EN
        chk("cnt_loaduse", 64'(cnt_loaduse), 64'(events[0]));
        chk("cnt_mispred", 64'(cnt_mispred), 64'(events[1]));
        chk("cnt_ret",     64'(cnt_ret),     64'(events[2]));
        chk("cnt_memwait", 64'(cnt_memwait), 64'(events[3]));
`endif
    endtask

    // Called at a negedge with inputs set; checks, clocks, returns at next negedge
    task automatic step(input string tag);
        #1;
        chk(tag, 64'(dut_vec), 64'(expect_out()));
        chk_cnt();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out", 64'(dut_vec), 64'(expect_out()));
        chk("rst_halted", 64'({halted, mem_timeout}), 64'(0));
        chk_cnt();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
        m_stat = 4'b1000; W_stat = 4'b1000;
        m_mem_req = 1'b0; m_mem_ready = 1'b0;
    endtask

    function automatic logic [3:0] rnd_icode();
        case ($urandom_range(0, 6))
            0: return 4'h5;
            1: return 4'h7;
            2: return 4'h9;
            3: return 4'hB;
            4: return 4'h0;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    endfunction

    function automatic logic [3:0] rnd_stat(input int one_in);
        logic [3:0] bad [3];
        bad[0] = 4'b0100; bad[1] = 4'b0010; bad[2] = 4'b0001;
        return ($urandom_range(0, one_in - 1) == 0) ? bad[$urandom_range(0, 2)] : 4'b1000;
    endfunction

    initial begin
        idle();
        do_reset();

        // Load-use, then the same with NO_REG destination
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1 chk("loaduse", 64'({F_stall, D_stall, E_bubble, D_bubble}), 64'(4'b1110));
        step("loaduse_m");
        E_dstM = 4'hF;
        #1 chk("loaduse_noreg", 64'(ctrl9), 64'(0));
        step("loaduse_noreg_m");

        // Mispredict, then correctly predicted
        idle(); E_icode = 4'h7; e_Cnd = 1'b0;
        #1 chk("mispred", 64'({D_bubble, E_bubble, F_stall}), 64'(3'b110));
        step("mispred_m");
        e_Cnd = 1'b1;
        #1 chk("taken", 64'(ctrl9), 64'(0));
        step("taken_m");

        // ret moving through D, E, M
        for (int k = 0; k < 3; k++) begin
            idle();
            if (k == 0) D_icode = 4'h9; else if (k == 1) E_icode = 4'h9; else M_icode = 4'h9;
            #1 chk("ret", 64'({F_stall, D_bubble}), 64'(2'b11));
            step("ret_m");
        end

        // Memory wait 3 cycles, ready on the 4th, back to normal flow
        idle(); m_mem_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("memwait", 64'({F_stall, D_stall, E_stall, M_stall, W_bubble}), 64'(5'b11111));
            step("memwait_m");
        end
        m_mem_ready = 1'b1;
        step("memready");
        idle();
        #1 chk("mw_back", 64'(ctrl9), 64'(0));
        step("mw_back_m");

        // Timeout with ready never arriving
        m_mem_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("to_pending", 64'(halted), 64'(0));
            step("to_m");
        end
        #1 chk("to_halt", 64'({halted, mem_timeout}), 64'(2'b11));
        step("to_halt_m");
        idle();
        do_reset();

        // Exception drain and halt
        m_stat = 4'b0010;
        #1 chk("exc_m", 64'({M_bubble, setcc}), 64'(2'b10));
        step("exc_m_m");
        #1 chk("drain", 64'({F_stall, D_stall, M_bubble, W_stall, setcc}), 64'(5'b11100));
        step("drain_m");
        W_stat = 4'b0010;
        #1 chk("drain_w", 64'(W_stall), 64'(1));
        step("drain_w_m");
        #1 chk("exc_halt", 64'(halted), 64'(1));
        step("exc_halt_m");
        idle();
        do_reset();

`ifdef HAZ_PERF_CNT_EN
        E_icode = 4'h7; e_Cnd = 1'b0;
        repeat (5) step("perf_m");
        chk("cnt_mp5", 64'(cnt_mispred), 64'(5));
        repeat (3) step("perf_sat_m");
        chk("cnt_mp_sat", 64'(cnt_mispred), 64'(7));
        idle();
        do_reset();
`endif

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            D_icode = rnd_icode(); E_icode = rnd_icode(); M_icode = rnd_icode();
            d_srcA = rnd_reg(); d_srcB = rnd_reg(); E_dstM = rnd_reg();
            e_Cnd = 1'($urandom_range(0, 1));
            m_stat = rnd_stat(25); W_stat = rnd_stat(40);
            m_mem_req = ($urandom_range(0, 2) == 0);
            m_mem_ready = 1'($urandom_range(0, 1));
            step("rand");
            if ((mode == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
